// File: rtl/csa_acc_resolve_40.sv
// Streaming carry-save accumulator: one 3:2 compression per accepted beat, then
// a chunked carry-propagate resolve (CHUNK bits per cycle) into a binary result.
module csa_acc_resolve_40 #(
    parameter int WIDTH = 40,
    parameter int CHUNK = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ACC,
        RESOLVE,
        OUT
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] s_reg, c_reg;
    logic             ovf_reg;
    logic [IW-1:0]    idx;
    logic             chunk_cy;

    logic [WIDTH-1:0] s_next, maj, c_next;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    int               base;

    // 3:2 compression of the new operand into the redundant running sum.
    always_comb begin
        s_next = in_data ^ s_reg ^ c_reg;
        maj    = (in_data & s_reg) | (in_data & c_reg) | (s_reg & c_reg);
        c_next = {maj[WIDTH-2:0], 1'b0};
    end

    assign base       = int'(idx) * CHUNK;
    assign chunk_sum  = {1'b0, s_reg[base +: CHUNK]} + {1'b0, c_reg[base +: CHUNK]}
                      + {{CHUNK{1'b0}}, chunk_cy};
    assign last_chunk = (idx == IW'(NCHUNK - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = !rst;
                if (in_valid && in_last) state_next = RESOLVE;
            end
            RESOLVE: begin
                if (last_chunk) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg    <= '0;
            c_reg    <= '0;
            ovf_reg  <= 1'b0;
            idx      <= '0;
            chunk_cy <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        s_reg    <= s_next;
                        c_reg    <= c_next;
                        // Top-bit carry has weight 2^WIDTH: record it, never drop it silently.
                        ovf_reg  <= ovf_reg | maj[WIDTH-1];
                        idx      <= '0;
                        chunk_cy <= 1'b0;
                    end
                end
                RESOLVE: begin
                    out_data[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    chunk_cy                <= chunk_sum[CHUNK];
                    idx                     <= idx + 1'b1;
                    if (last_chunk) begin
                        ovf_reg <= ovf_reg | chunk_sum[CHUNK];
                        out_ovf <= ovf_reg | chunk_sum[CHUNK];
                    end
                end
                OUT: begin
                    // out_data/out_ovf stay put; only the accumulator restarts.
                    if (out_ready) begin
                        s_reg   <= '0;
                        c_reg   <= '0;
                        ovf_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_acc_resolve_40.sv
// Self-checking bench for csa_acc_resolve_40: directed scenarios plus random
// packets checked against a plain-integer packet-sum model.
module tb_csa_acc_resolve_40;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;

    logic [39:0] beats_q[$];

    csa_acc_resolve_40 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: true integer sum of the packet, split into mod-2^40 and overflow.
    task automatic model_result(output logic [39:0] d, output logic o);
        logic [63:0] sum;
        sum = 64'd0;
        foreach (beats_q[i]) sum = sum + {24'd0, beats_q[i]};
        d = sum[39:0];
        o = (sum[63:40] != 24'd0);
    endtask

    function automatic logic [39:0] rand40();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    // Drives beats_q as one packet; returns just after the edge that took in_last.
    task automatic drive_packet(input int max_gap, output bit ok);
        int cnt;
        ok = 1'b1;
        for (int i = 0; i < beats_q.size(); i++) begin
            if (max_gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beats_q[i];
            in_last  = (i == beats_q.size() - 1);
            cnt = 0;
            while (!in_ready && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            if (!in_ready) begin
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen (first count is the one right after accept).
    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input int max_gap, input bit check_lat);
        bit ok, vok;
        int cyc;
        logic [39:0] ed;
        logic eo;
        model_result(ed, eo);
        drive_packet(max_gap, ok);
        wait_valid(cyc, vok);
        checks++;
        if (!ok || !vok) begin
            errors++;
            $display("FAIL %s handshake: accept_ok=%0b valid_seen=%0b", name, ok, vok);
        end
        if (check_lat) begin
            checks++;
            if (cyc !== 5) begin
                errors++;
                $display("FAIL %s latency: got %0d negedges, want 5", name, cyc);
            end
        end
        checks++;
        if (out_data !== ed || out_ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got %h ovf=%0b, want %h ovf=%0b", name, out_data, out_ovf, ed, eo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 40'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b data=%h ovf=%0b, want 0 0 0 0",
                     in_ready, out_valid, out_data, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        beats_q = '{40'h12_3456_789A};
        run_and_check("single_beat", 0, 1'b1);
    endtask

    task automatic test_small_packet();
        bit ok;
        int low = 0;
        logic seen_valid = 1'b0;
        beats_q = '{40'd1, 40'd2, 40'd3};
        drive_packet(0, ok);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n <= 5 && !in_ready) low++;
            if (n == 5) begin
                seen_valid = out_valid;
                checks++;
                if (out_data !== 40'd6 || out_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL small_packet result: got %h ovf=%0b, want 6 ovf=0", out_data, out_ovf);
                end
            end
            if (n == 6) begin
                checks++;
                if (in_ready !== 1'b1 || low !== 5 || !ok || seen_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL small_packet in_ready: low_cycles=%0d ready_after=%0b valid=%0b, want 5 1 1",
                             low, in_ready, seen_valid);
                end
            end
        end
    endtask

    task automatic test_chunk_carry();
        beats_q = '{40'h00_0000_03FF, 40'h00_0000_0001};
        run_and_check("chunk01_carry", 0, 1'b1);
        beats_q = '{40'h00_FFFF_FFFF, 40'h00_0000_0001};
        run_and_check("full_ripple", 0, 1'b0);
    endtask

    task automatic test_overflow();
        beats_q = '{40'hFF_FFFF_FFFF, 40'h00_0000_0001};
        run_and_check("overflow", 0, 1'b0);
        beats_q = '{40'h00_0000_0005};
        run_and_check("ovf_cleared", 0, 1'b0);
    endtask

    task automatic test_backpressure();
        bit ok, vok;
        int cyc;
        int bad = 0;
        logic [39:0] ed, held, h_data;
        logic eo, h_ovf;
        beats_q = '{rand40(), rand40(), rand40()};
        model_result(ed, eo);
        out_ready = 1'b0;
        drive_packet(0, ok);
        wait_valid(cyc, vok);
        held = rand40();
        in_valid = 1'b1; in_data = held; in_last = 1'b0;
        h_data = out_data; h_ovf = out_ovf;
        checks++;
        if (!vok || out_data !== ed || out_ovf !== eo) begin
            errors++;
            $display("FAIL backpressure result: got %h ovf=%0b, want %h ovf=%0b", out_data, out_ovf, ed, eo);
        end
        repeat (10) begin
            @(negedge clk);
            if (out_data !== h_data || out_ovf !== h_ovf || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure hold: %0d unstable cycles, want 0", bad);
        end
        out_ready = 1'b1;
        beats_q = '{held, rand40()};
        run_and_check("held_beat_packet", 0, 1'b1);
    endtask

    task automatic test_reset_mid_resolve();
        bit ok;
        int bad = 0;
        beats_q = '{40'd7, 40'd9};
        drive_packet(0, ok);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid in_ready during rst: got %0b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 40'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid state: valid=%0b data=%h ovf=%0b ready=%0b, want 0 0 0 1",
                     out_valid, out_data, out_ovf, in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid no_output: out_valid high %0d cycles, want 0", bad);
        end
        beats_q = '{40'h2A};
        run_and_check("after_rst", 0, 1'b1);
    endtask

    task automatic test_random_packets();
        int len, hold, bad;
        bit ok, vok;
        int cyc;
        logic [39:0] ed, h_data;
        logic eo, h_ovf;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 5);
            beats_q.delete();
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 2) == 0) beats_q.push_back(40'hF0_0000_0000 | rand40());
                else beats_q.push_back(rand40());
            end
            model_result(ed, eo);
            hold = $urandom_range(0, 3);
            out_ready = 1'b0;
            drive_packet(2, ok);
            wait_valid(cyc, vok);
            h_data = out_data; h_ovf = out_ovf;
            bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (out_data !== h_data || out_ovf !== h_ovf || !out_valid) bad++;
            end
            checks++;
            if (!ok || !vok || bad != 0 || out_data !== ed || out_ovf !== eo) begin
                errors++;
                $display("FAIL random_pkt%0d: got %h ovf=%0b, want %h ovf=%0b (ok=%0b valid=%0b unstable=%0d)",
                         p, out_data, out_ovf, ed, eo, ok, vok, bad);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_small_packet();
        test_chunk_carry();
        test_overflow();
        test_backpressure();
        test_reset_mid_resolve();
        test_random_packets();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
